adc_avg_fifo: RTL and testbench
===============================

// Module: adc_avg_fifo
// PURPOSE
// Downstream consumer of the ADC imitator/interface frame stream (sck/CS/en/16-bit data).
// Captures one sample per frame on the CS rising edge, averages 2^LOG2_N consecutive samples
// (decimation by N) and queues each mean in a small FIFO that the readout logic drains via rd_en.
// Flags FIFO overflow so lost averages are visible to software.
// PARAMETERS
// DATA_W   16  sample and average width, bits
// LOG2_N   2   log2 of samples per average (N = 4); valid range 0..8
// FIFO_AW  4   FIFO address width; depth = 2^FIFO_AW = 16 words
// PORTS
// clk_100     in   1          system clock, all logic on rising edge
// reset       in   1          synchronous, active-low reset
// enable      in   1          run; low = synchronous clear of datapath, FIFO and flags
// cs_in       in   1          ADC frame CS; rising edge marks a stable sample
// en_in       in   1          ADC data-valid level; samples ignored while low
// adc_data_in in   DATA_W     sample, stable when cs_in rises
// rd_en       in   1          read request; honoured only when empty = 0
// dout        out  DATA_W     FIFO read data, registered
// dout_valid  out  1          1-cycle pulse: dout holds a newly read word
// fifo_count  out  FIFO_AW+1  words stored, 0..2^FIFO_AW
// empty       out  1          fifo_count == 0
// full        out  1          fifo_count == 2^FIFO_AW
// overflow    out  1          sticky: an average was dropped because FIFO was full
// BEHAVIOUR
// - Reset (reset = 0) values: dout 0, dout_valid 0, fifo_count 0, empty 1, full 0, overflow 0;
//   accumulator 0, sample counter 0, wr/rd pointers 0, cs_d (registered cs_in) = 1.
// - cs_d resets to 1: cs_in already high when reset is released gives no false strobe.
// - strobe = cs_in & ~cs_d & en_in & enable; cs_d <= cs_in every cycle.
// - Accumulator width DATA_W+LOG2_N, unsigned, cannot overflow for N samples.
// - On strobe, cnt < N-1: acc <= acc + adc_data_in; cnt <= cnt + 1.
// - On strobe, cnt == N-1: avg = (acc + adc_data_in) >> LOG2_N (truncate, no rounding);
//   push avg to FIFO in the same cycle; acc <= 0; cnt <= 0. fifo_count updates next cycle.
// - LOG2_N = 0: every strobe pushes adc_data_in unchanged.
// - Pop: rd_en & ~empty -> dout <= mem[rd_ptr], rd_ptr++, dout_valid = 1 the next cycle.
//   rd_en while empty: ignored, dout holds, dout_valid 0, no pointer change.
// - Push accepted if ~full, or if full and a pop occurs in the same cycle.
// - Simultaneous push and pop: both occur, fifo_count unchanged.
// - Push while full with no pop: word dropped, overflow <= 1, pointers/count unchanged.
// - Pointers wrap modulo 2^FIFO_AW; full/empty derived from fifo_count, not pointer compare.
// - overflow clears only on reset = 0 or enable = 0.
// - enable = 0: acc, cnt, pointers, fifo_count, overflow, dout_valid cleared next edge;
//   dout holds its value; cs_d keeps tracking cs_in. A partial average is discarded.
// - en_in low on a CS edge: sample skipped, partial accumulation retained.
// - Reset mid-frame or mid-average: all state returns to reset values; FIFO contents lost.
// TESTING
// - Reset with cs_in = 1, release -> no strobe, fifo_count 0, empty 1, all outputs at reset values.
// - N = 4, frames with data 1,2,3,4,5,6,7,8 -> FIFO holds 2 then 6; two rd_en pulses -> dout 2, 6.
// - 17 averages with no reads -> fifo_count 16, full 1, overflow 1; 16 reads return first 16 only.
// - Full FIFO, rd_en on the cycle the 17th average is pushed -> count stays 16, overflow 0.
// - en_in = 0 on frame 2 of data 10,20,30,40,50 -> average (10+30+40+50)>>2 = 32.
// - enable = 0 after 2 samples and 3 queued words -> count 0, overflow 0; restart averages fresh.

Source files
------------

// File: rtl/adc_avg_fifo_if.sv
// Bundle of ADC frame inputs and FIFO readout signals for adc_avg_fifo.
// master: the side that drives the frame stream and read requests (bench / upstream).
// slave:  the averaging FIFO itself.
interface adc_avg_fifo_if #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 4
);
  logic                cs_in;
  logic                en_in;
  logic [DATA_W-1:0]   adc_data_in;
  logic                rd_en;
  logic [DATA_W-1:0]   dout;
  logic                dout_valid;
  logic [FIFO_AW:0]    fifo_count;
  logic                empty;
  logic                full;
  logic                overflow;

  modport master (
    output cs_in, en_in, adc_data_in, rd_en,
    input  dout, dout_valid, fifo_count, empty, full, overflow
  );

  modport slave (
    input  cs_in, en_in, adc_data_in, rd_en,
    output dout, dout_valid, fifo_count, empty, full, overflow
  );
endinterface

// File: rtl/adc_avg_fifo.sv
// adc_avg_fifo: captures one ADC sample per frame on the CS rising edge,
// averages 2^LOG2_N consecutive samples (truncating) and queues each mean
// in a 2^FIFO_AW-deep FIFO. A sticky overflow flag records dropped averages.
module adc_avg_fifo #(
  parameter int DATA_W  = 16,
  parameter int LOG2_N  = 2,
  parameter int FIFO_AW = 4
) (
  input  logic           clk_100,
  input  logic           reset,
  input  logic           enable,
  adc_avg_fifo_if.slave  bus
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  // Registered state
  logic                 cs_dly_q;
  logic [ACC_W-1:0]     acc_q,      acc_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [FIFO_AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [FIFO_AW:0]     count_q,    count_d;
  logic                 empty_q,    empty_d;
  logic                 full_q,     full_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_W-1:0]    dout_q,     dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  // Combinational datapath / control
  logic                 strobe_s;
  logic                 last_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 push_ok_s;
  logic                 drop_s;
  logic [ACC_W-1:0]     sum_s;
  logic [DATA_W-1:0]    avg_s;

  // A sample is taken on a CS rising edge only while data is valid and the block runs.
  assign strobe_s  = bus.cs_in & ~cs_dly_q & bus.en_in & enable;
  assign last_s    = (cnt_q == CNT_LAST);
  assign sum_s     = acc_q + ACC_W'(bus.adc_data_in);
  assign avg_s     = DATA_W'(sum_s >> LOG2_N);
  assign push_s    = strobe_s & last_s;
  assign pop_s     = bus.rd_en & ~empty_q & enable;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok_s = push_s & (~full_q | pop_s);
  assign drop_s    = push_s & full_q & ~pop_s;

  // Next-state logic for accumulator, pointers, occupancy, flags and read port.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (!enable) begin
      // Run low discards any partial average and empties the queue; dout holds.
      acc_d      = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (strobe_s) begin
        if (last_s) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = sum_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end

      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d     = rd_ptr_q + FIFO_AW'(1);
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end else begin
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
      end

      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end

    // Status flags come from occupancy, never from pointer comparison.
    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_FULL);
  end

  // State register with synchronous active-low reset; cs delay resets high.
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      cs_dly_q     <= 1'b1;
      acc_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cs_dly_q     <= bus.cs_in;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_100) begin
    if (reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= avg_s;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.fifo_count = count_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Self-checking bench for adc_avg_fifo: directed scenarios with random sample
// data, checked against a queue-based reference model of the averaging FIFO.
module tb_adc_avg_fifo;

  localparam int DATA_W  = 16;
  localparam int LOG2_N  = 2;
  localparam int FIFO_AW = 4;
  localparam int N       = 1 << LOG2_N;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic clk_100 = 1'b0;
  logic reset   = 1'b0;
  logic enable  = 1'b1;

  adc_avg_fifo_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) bus ();

  adc_avg_fifo #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .FIFO_AW(FIFO_AW)) dut (
    .clk_100 (clk_100),
    .reset   (reset),
    .enable  (enable),
    .bus     (bus)
  );

  always #5 clk_100 = ~clk_100;

  // Reference model state
  int mq[$];        // queued averages
  int samp[$];      // samples of the average in progress
  int m_ovf;
  int m_dout;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"},    int'(bus.fifo_count), mq.size());
    chk({tag, ".empty"},    int'(bus.empty),      (mq.size() == 0) ? 1 : 0);
    chk({tag, ".full"},     int'(bus.full),       (mq.size() == DEPTH) ? 1 : 0);
    chk({tag, ".overflow"}, int'(bus.overflow),   m_ovf);
  endtask

  // One ADC frame: CS low with data, then CS high (sample edge). Optional read on that edge.
  task automatic frame(input int d, input bit v, input bit rd);
    int  sum;
    bit  popped;
    bus.cs_in       = 1'b0;
    bus.adc_data_in = d[DATA_W-1:0];
    bus.en_in       = v;
    step();
    bus.cs_in = 1'b1;
    bus.rd_en = rd;
    step();
    bus.rd_en = 1'b0;
    popped = 1'b0;
    if (rd && mq.size() > 0) begin
      m_dout = mq.pop_front();
      popped = 1'b1;
    end
    if (v) begin
      samp.push_back(d);
      if (samp.size() == N) begin
        sum = 0;
        foreach (samp[i]) sum += samp[i];
        samp.delete();
        if (mq.size() < DEPTH) mq.push_back(sum / N);
        else m_ovf = 1;
      end
    end
    if (rd) begin
      chk("frame_rd.valid", int'(bus.dout_valid), popped ? 1 : 0);
      chk("frame_rd.dout",  int'(bus.dout),       m_dout);
    end
  endtask

  task automatic pop_chk(input string tag);
    bit popped;
    popped = 1'b0;
    if (mq.size() > 0) begin
      m_dout = mq.pop_front();
      popped = 1'b1;
    end
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk({tag, ".valid"}, int'(bus.dout_valid), popped ? 1 : 0);
    chk({tag, ".dout"},  int'(bus.dout),       m_dout);
  endtask

  task automatic run_clear();
    enable = 1'b0;
    step();
    enable = 1'b1;
    mq.delete();
    samp.delete();
    m_ovf = 0;
  endtask

  initial begin
    int d;
    bus.cs_in       = 1'b1;
    bus.en_in       = 1'b1;
    bus.adc_data_in = 16'd100;
    bus.rd_en       = 1'b0;
    m_ovf  = 0;
    m_dout = 0;

    // Reset with CS already high, then release: no false strobe.
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    step();
    chk_status("reset");
    chk("reset.dout",  int'(bus.dout),       0);
    chk("reset.valid", int'(bus.dout_valid), 0);

    // Read while empty is ignored.
    pop_chk("rd_empty");

    // Data 1..8 -> averages 2 and 6.
    for (int i = 1; i <= 8; i++) frame(i, 1'b1, 1'b0);
    chk("avg18.count", int'(bus.fifo_count), 2);
    chk_status("avg18");
    pop_chk("avg18.pop0");
    chk("avg18.first", m_dout, 2);
    pop_chk("avg18.pop1");
    chk("avg18.second", m_dout, 6);
    chk_status("avg18.drained");

    // 17 random averages without reads: full, overflow, first 16 kept.
    for (int a = 0; a < 17; a++)
      for (int s = 0; s < N; s++) frame(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    chk_status("ovf17");
    chk("ovf17.flag", int'(bus.overflow), 1);
    for (int i = 0; i < DEPTH; i++) pop_chk("ovf17.drain");
    chk_status("ovf17.drained");
    chk("ovf17.sticky", int'(bus.overflow), 1);
    pop_chk("ovf17.rd_empty");

    // Clear, refill to full, then read on the cycle the 17th average is pushed.
    run_clear();
    chk_status("clear1");
    for (int a = 0; a < DEPTH; a++)
      for (int s = 0; s < N; s++) frame(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    chk_status("full16");
    for (int s = 0; s < N - 1; s++) frame(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    frame(int'($urandom_range(0, 65535)), 1'b1, 1'b1);
    chk_status("push_pop_full");
    for (int i = 0; i < DEPTH; i++) pop_chk("push_pop_full.drain");
    chk_status("push_pop_full.drained");

    // en_in low on frame 2 of 10,20,30,40,50 -> (10+30+40+50)>>2 = 32.
    run_clear();
    frame(10, 1'b1, 1'b0);
    frame(20, 1'b0, 1'b0);
    frame(30, 1'b1, 1'b0);
    frame(40, 1'b1, 1'b0);
    frame(50, 1'b1, 1'b0);
    chk_status("en_skip");
    pop_chk("en_skip.pop");
    chk("en_skip.avg", m_dout, 32);

    // Three queued words plus two partial samples, then run low.
    for (int a = 0; a < 3 * N + 2; a++) frame(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    chk("pre_clear.count", int'(bus.fifo_count), 3);
    d = m_dout;
    run_clear();
    chk_status("clear2");
    chk("clear2.valid", int'(bus.dout_valid), 0);
    chk("clear2.dout_hold", int'(bus.dout), d);
    // Fresh average after restart ignores the discarded partial samples.
    for (int s = 0; s < N; s++) frame(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    chk_status("restart");
    pop_chk("restart.pop");

    // Reset mid-average with queued data: everything returns to reset values.
    for (int a = 0; a < N + 1; a++) frame(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    mq.delete();
    samp.delete();
    m_ovf  = 0;
    m_dout = 0;
    chk_status("reset2");
    chk("reset2.dout", int'(bus.dout), 0);
    for (int i = 0; i < N; i++) frame(4 * i + 1, 1'b1, 1'b0);
    pop_chk("reset2.pop");
    chk("reset2.avg", m_dout, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
